// File: rtl/matrix_sequencer.sv
// Sequences operand bytes into a 2x2 FP8 matrix controller, waits for the
// compute to finish, drains, reads the four results and streams them out.
module matrix_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  // upstream operand stream
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  // controller load port
  output logic       load_en,
  output logic       load_sel_ab,
  output logic [1:0] load_index,
  output logic [7:0] load_data,
  // controller compute / result port
  input  logic       done,
  output logic       output_en,
  output logic [1:0] output_sel,
  input  logic [7:0] out_data,
  // downstream result stream
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  // sticky timeout flag
  output logic       err
);

  localparam int unsigned DW      = 8;
  localparam int unsigned BC_W    = 3;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned WC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned DC_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned WC_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int unsigned DC_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_WAIT_DONE = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_READ      = 3'd3,
    ST_SEND      = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [BC_W-1:0]           bc_q, bc_d;
  logic [WC_W-1:0]           wc_q, wc_d;
  logic [DC_W-1:0]           dc_q, dc_d;
  logic [IDX_W-1:0]          kc_q, kc_d;
  logic [3:0][DW-1:0]        rb_q, rb_d;

  logic                      s_ready_q, s_ready_d;
  logic                      load_en_q, load_en_d;
  logic                      load_sel_q, load_sel_d;
  logic [IDX_W-1:0]          load_index_q, load_index_d;
  logic [DW-1:0]             load_data_q, load_data_d;
  logic                      output_en_q, output_en_d;
  logic [IDX_W-1:0]          output_sel_q, output_sel_d;
  logic                      m_valid_q, m_valid_d;
  logic [DW-1:0]             m_data_q, m_data_d;
  logic                      m_last_q, m_last_d;
  logic                      err_q, err_d;

  logic                      xfer_c;

  // An upstream byte is taken only while loading and advertising ready
  assign xfer_c = s_valid && s_ready_q && (state_q == ST_LOAD);

  // Next-state and next-output logic for the whole sequencer
  always_comb begin
    state_d      = state_q;
    bc_d         = bc_q;
    wc_d         = wc_q;
    dc_d         = dc_q;
    kc_d         = kc_q;
    rb_d         = rb_q;
    load_en_d    = 1'b0;
    load_sel_d   = load_sel_q;
    load_index_d = load_index_q;
    load_data_d  = load_data_q;
    output_en_d  = 1'b0;
    output_sel_d = output_sel_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    err_d        = err_q;

    unique case (state_q)
      ST_LOAD: begin
        if (xfer_c) begin
          load_en_d    = 1'b1;
          load_sel_d   = bc_q[2];
          load_index_d = bc_q[1:0];
          load_data_d  = s_data;
          bc_d         = bc_q + BC_W'(1);
          if (bc_q == BC_W'(7)) begin
            state_d = ST_WAIT_DONE;
            wc_d    = '0;
          end
        end
      end

      ST_WAIT_DONE: begin
        // done beats a coincident timeout
        if (done) begin
          if (DRAIN_CYCLES == 0) begin
            state_d      = ST_READ;
            output_en_d  = 1'b1;
            output_sel_d = '0;
          end else begin
            state_d = ST_DRAIN;
            dc_d    = '0;
          end
        end else if (wc_q == WC_W'(WC_LAST)) begin
          state_d = ST_LOAD;
          bc_d    = '0;
          err_d   = 1'b1;
        end else begin
          wc_d = wc_q + WC_W'(1);
        end
      end

      ST_DRAIN: begin
        if (dc_q == DC_W'(DC_LAST)) begin
          state_d      = ST_READ;
          output_en_d  = 1'b1;
          output_sel_d = '0;
        end else begin
          dc_d = dc_q + DC_W'(1);
        end
      end

      ST_READ: begin
        // controller never stalls: one result per output_en cycle
        rb_d[output_sel_q] = out_data;
        if (output_sel_q == IDX_W'(3)) begin
          state_d      = ST_SEND;
          output_sel_d = '0;
          kc_d         = '0;
          m_valid_d    = 1'b1;
          m_data_d     = rb_q[0];
          m_last_d     = 1'b0;
        end else begin
          output_en_d  = 1'b1;
          output_sel_d = output_sel_q + IDX_W'(1);
        end
      end

      ST_SEND: begin
        if (m_valid_q && m_ready) begin
          if (kc_q == IDX_W'(3)) begin
            state_d   = ST_LOAD;
            bc_d      = '0;
            kc_d      = '0;
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_last_d  = 1'b0;
          end else begin
            kc_d     = kc_q + IDX_W'(1);
            m_data_d = rb_q[kc_q + IDX_W'(1)];
            m_last_d = (kc_q == IDX_W'(2));
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
        bc_d    = '0;
      end
    endcase

    s_ready_d = (state_d == ST_LOAD);
  end

  // State, counters, result buffer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      bc_q         <= '0;
      wc_q         <= '0;
      dc_q         <= '0;
      kc_q         <= '0;
      rb_q         <= '0;
      s_ready_q    <= 1'b0;
      load_en_q    <= 1'b0;
      load_sel_q   <= 1'b0;
      load_index_q <= '0;
      load_data_q  <= '0;
      output_en_q  <= 1'b0;
      output_sel_q <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bc_q         <= bc_d;
      wc_q         <= wc_d;
      dc_q         <= dc_d;
      kc_q         <= kc_d;
      rb_q         <= rb_d;
      s_ready_q    <= s_ready_d;
      load_en_q    <= load_en_d;
      load_sel_q   <= load_sel_d;
      load_index_q <= load_index_d;
      load_data_q  <= load_data_d;
      output_en_q  <= output_en_d;
      output_sel_q <= output_sel_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      err_q        <= err_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign load_en     = load_en_q;
  assign load_sel_ab = load_sel_q;
  assign load_index  = load_index_q;
  assign load_data   = load_data_q;
  assign output_en   = output_en_q;
  assign output_sel  = output_sel_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_last      = m_last_q;
  assign err         = err_q;

endmodule

// File: tb/tb_matrix_sequencer.sv
// Directed + randomized bench for matrix_sequencer with a transaction-level model.
module tb_matrix_sequencer;

  localparam int DR = 2;
  localparam int TO = 15;

  logic       clk, rst_n;
  logic       s_valid, s_ready;
  logic [7:0] s_data;
  logic       load_en, load_sel_ab;
  logic [1:0] load_index;
  logic [7:0] load_data;
  logic       done, output_en;
  logic [1:0] output_sel;
  logic [7:0] out_data;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic       m_last, err;

  logic [7:0] ctrl_tab [4];
  logic [7:0] bytes_v  [8];
  bit         fpat     [7];
  logic [26:0] outs;

  int checks = 0;
  int errors = 0;
  int le_cnt = 0;
  int oe_cnt = 0;
  bit exp_err = 1'b0;

  matrix_sequencer #(.DRAIN_CYCLES(DR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .load_en(load_en), .load_sel_ab(load_sel_ab), .load_index(load_index), .load_data(load_data),
    .done(done), .output_en(output_en), .output_sel(output_sel), .out_data(out_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err(err)
  );

  // Controller model: result element selected combinationally by output_sel
  assign out_data = ctrl_tab[output_sel];
  assign outs = {s_ready, load_en, load_sel_ab, load_index, load_data, output_en,
                 output_sel, m_valid, m_data, m_last, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters used to prove no extra strobes appear
  always @(posedge clk) begin
    if (load_en)   le_cnt <= le_cnt + 1;
    if (output_en) oe_cnt <= oe_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream bytes_v with s_valid held high; expect one load strobe per cycle
  task automatic load8();
    chk("load_start_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = bytes_v[0];
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("load_en",    32'(load_en), 32'd1);
      chk("load_sel",   32'(load_sel_ab), 32'(i / 4));
      chk("load_index", 32'(load_index), 32'(i % 4));
      chk("load_data",  32'(load_data), 32'(bytes_v[i]));
      s_data = (i < 7) ? bytes_v[i + 1] : 8'($urandom);
    end
    chk("s_ready_after8", 32'(s_ready), 32'd0);
  endtask

  // done after d WAIT_DONE cycles (d >= TO means the timeout fires first)
  task automatic compute(input int d, output bit to);
    to = (d >= TO);
    if (!to) begin
      for (int j = 0; j < d; j++) begin
        chk("wait_oe", 32'(output_en), 32'd0);
        tick();
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      for (int j = 0; j < DR; j++) begin
        chk("drain_oe", 32'(output_en), 32'd0);
        tick();
      end
      for (int j = 0; j < 4; j++) begin
        chk("read_oe",  32'(output_en), 32'd1);
        chk("read_sel", 32'(output_sel), 32'(j));
        tick();
      end
      chk("read_end_oe", 32'(output_en), 32'd0);
    end else begin
      s_valid = 1'b0;
      for (int j = 0; j < TO - 1; j++) tick();
      chk("to_early", 32'(s_ready), 32'd0);
      tick();
      chk("to_ready", 32'(s_ready), 32'd1);
      chk("to_err",   32'(err), 32'd1);
      exp_err = 1'b1;
      if (d == TO) begin
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("done_in_load_oe",    32'(output_en), 32'd0);
        chk("done_in_load_ready", 32'(s_ready), 32'd1);
      end
    end
  endtask

  // Drain the four results; pm: 0 always ready, 1 fixed toggle pattern, 2 random
  task automatic send_phase(input int pm, input bit dis);
    int k = 0;
    int n = 0;
    bit r;
    while (k < 4 && n < 64) begin
      chk("m_valid", 32'(m_valid), 32'd1);
      chk("m_data",  32'(m_data), 32'(ctrl_tab[k]));
      chk("m_last",  32'(m_last), 32'(k == 3));
      case (pm)
        0:       r = 1'b1;
        1:       r = (n < 7) ? fpat[n] : 1'b1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      m_ready = r;
      if (dis) done = 1'($urandom_range(0, 1));
      if (r && k == 3) s_valid = 1'b0;
      tick();
      n++;
      if (r) k++;
    end
    m_ready = 1'b0;
    done    = 1'b0;
    chk("send_bound",     32'(k == 4), 32'd1);
    chk("send_end_valid", 32'(m_valid), 32'd0);
    chk("send_end_last",  32'(m_last), 32'd0);
    chk("send_end_ready", 32'(s_ready), 32'd1);
  endtask

  task automatic txn(input int d, input int pm, input bit dis);
    int le0;
    int oe0;
    bit to;
    le0 = le_cnt;
    oe0 = oe_cnt;
    load8();
    compute(d, to);
    if (!to) send_phase(pm, dis);
    chk("load_pulses", 32'(le_cnt - le0), 32'd8);
    chk("oe_pulses",   32'(oe_cnt - oe0), to ? 32'd0 : 32'd4);
    chk("err_sticky",  32'(err), 32'(exp_err));
  endtask

  task automatic rand_operands();
    for (int i = 0; i < 8; i++) bytes_v[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) ctrl_tab[i] = 8'($urandom);
  endtask

  initial begin
    fpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; done = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) ctrl_tab[i] = '0;

    // reset behaviour
    tick(); tick();
    chk("rst_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    chk("rst_rel_pre", 32'(s_ready), 32'd0);
    tick();
    chk("rst_rel_ready", 32'(s_ready), 32'd1);
    chk("rst_rel_err",   32'(err), 32'd0);

    // bytes 01..08, done right after loading, results 0x40+sel
    for (int i = 0; i < 8; i++) bytes_v[i] = 8'(i + 1);
    for (int i = 0; i < 4; i++) ctrl_tab[i] = 8'(8'h40 + i);
    txn(0, 0, 1'b0);

    // back-pressure pattern with s_valid held and done pulsed during SEND
    rand_operands();
    txn(3, 1, 1'b1);

    // done coincident with the timeout cycle wins
    rand_operands();
    txn(TO - 1, 2, 1'b1);

    // timeout, then a late done while back in LOAD
    rand_operands();
    txn(TO, 2, 1'b0);

    // err stays set across a normal transaction
    rand_operands();
    txn(1, 2, 1'b0);

    // reset after five loaded bytes
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'($urandom);
      tick();
    end
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", 32'(outs), 32'd0);
    tick();
    chk("rst_hold_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    exp_err = 1'b0;
    tick();
    chk("rst_mid_ready", 32'(s_ready), 32'd1);
    chk("rst_mid_err",   32'(err), 32'd0);
    rand_operands();
    txn(2, 2, 1'b0);

    // randomized transactions
    for (int t = 0; t < 10; t++) begin
      rand_operands();
      txn($urandom_range(0, TO), 2, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
